frame_sequencer: RTL and testbench
==================================

Name: frame_sequencer

Overview:
Generates the periodic tick strobes for the sound channels' modulation units from the system clock. A prescaler divides the system clock down to the 512 Hz frame rate. An 8-step counter then decodes it into length (256 Hz), sweep (128 Hz) and envelope (64 Hz) strobes. Sits directly upstream of the length counter, whose clock input is driven by len_tick, and likewise upstream of the sweep and envelope units.

Parameters:
DIV_COUNT, 8192, system clocks per frame step (4.194304 MHz / 512 Hz); must be >= 2
DIV_W, $clog2(DIV_COUNT), prescaler counter width (derived; not overridden)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
apu_on  input  1  APU master enable (NR52 bit 7); 0 holds block cleared
len_tick  output  1  one-cycle strobe on steps 0,2,4,6 (256 Hz)
sweep_tick  output  1  one-cycle strobe on steps 2,6 (128 Hz)
env_tick  output  1  one-cycle strobe on step 7 (64 Hz)
frame_tick  output  1  one-cycle strobe on every step (512 Hz)
step  output  3  current step index (value that the next strobe will decode)

Behaviour:
- Reset (rst_n=0, async): div_cnt=0, step=0, len_tick=sweep_tick=env_tick=frame_tick=0. Release is synchronous to the next clk edge; no strobe on the release edge.
- apu_on=0 (sync, priority over counting): div_cnt<=0, step<=0, all ticks<=0 each cycle. A power-off mid-step discards the partial count; there is no residual strobe.
- apu_on=1, div_cnt != DIV_COUNT-1: div_cnt<=div_cnt+1, ticks<=0.
- apu_on=1, div_cnt == DIV_COUNT-1 (step event):
  - div_cnt<=0; step<=step+1 (3-bit wrap 7->0).
  - frame_tick<=1.
  - len_tick<=(step[0]==0).
  - sweep_tick<=(step==2 or step==6).
  - env_tick<=(step==7).
  - All decodes use step before increment.
- Strobes are registered, high exactly one clk cycle, and never back-to-back (DIV_COUNT>=2).
- Latency: the first strobe, frame_tick+len_tick for step 0, occurs on the DIV_COUNT-th rising edge after apu_on is sampled high.
- Period per full 8-step cycle = 8*DIV_COUNT clocks.
  - len_tick: 4 strobes per cycle.
  - sweep_tick: 2 per cycle.
  - env_tick: 1 per cycle.
- Simultaneous strobes: on step 2 and step 6, len_tick and sweep_tick assert in the same cycle with frame_tick. On step 7, env_tick and frame_tick assert together, with no len_tick.
- apu_on re-asserted after an off period restarts at step 0 with a full DIV_COUNT delay.
- No other state; no combinational paths from inputs to outputs.

Optional Feature:
Macro FS_EXT_TICK_EN.
- Defined:
  - Adds input ext_tick (1 bit), a one-cycle 512 Hz strobe from the timer block (DIV bit-4 falling edge).
  - The prescaler is removed (DIV_COUNT unused); the step event occurs on any cycle with apu_on=1 and ext_tick=1.
  - Strobes are registered, so they appear one cycle after ext_tick.
  - apu_on=0 still clears step and ticks; ext_tick is ignored while apu_on=0.
- Undefined: no ext_tick port; the internal prescaler is used as above.

Test Plan:
1. DIV_COUNT=4. Reset, then apu_on=1 for 32 clks -> frame_tick at clks 4,8,...,32; len_tick at 4,12,20,28; sweep_tick at 12,28; env_tick at 32; step reads 1..7 then 0.
2. DIV_COUNT=4. Assert rst_n=0 asynchronously mid-count, at div_cnt=2 with step=5 -> all outputs 0 immediately, without waiting for a clk edge. After release with apu_on=1 -> first len_tick 4 clks later, step=1 afterwards.
3. DIV_COUNT=4. apu_on=0 at step=3, div_cnt=3 -> no strobe that cycle; step=0, div_cnt=0. Re-enable -> len_tick 4 clks later (step 0 decode).
4. DIV_COUNT=4. Run 64 clks -> exactly 16 frame_tick, 8 len_tick, 4 sweep_tick, 2 env_tick. Each strobe is 1 clk wide; len_tick coincides with sweep_tick only on steps 2 and 6.
5. Drive the length counter from len_tick with load 61, trigger, length enable 1 -> chanEnable drops after 3 len_tick strobes (clks 4,12,20 with DIV_COUNT=4).
6. FS_EXT_TICK_EN defined: pulse ext_tick 8 times at irregular intervals with apu_on=1 -> each pulse yields frame_tick next cycle; env_tick on the 8th pulse; an ext_tick while apu_on=0 produces nothing.

Source files
------------

// File: rtl/frame_sequencer.sv
//-----------------------------------------------------------------------------
// frame_sequencer
//
// Derives the periodic modulation strobes for the sound channels from the
// system clock. A prescaler divides the clock down to the 512 Hz frame rate,
// and an 8-step counter decodes each frame step into the length (256 Hz),
// sweep (128 Hz) and envelope (64 Hz) strobes used by the downstream length
// counter, sweep unit and envelope units.
//
// Build option:
//   FS_EXT_TICK_EN  When defined, the internal prescaler is removed and a
//                   step is taken on every cycle where ext_tick (the 512 Hz
//                   strobe from the timer block) is high while apu_on is high.
//                   DIV_COUNT is then unused. When undefined, there is no
//                   ext_tick port and the prescaler is used.
//
// Parameters:
//   DIV_COUNT   system clocks per frame step (default 8192 = 4.194304 MHz /
//               512 Hz); must be >= 2
//   DIV_W       prescaler counter width, derived from DIV_COUNT
//
// Ports:
//   clk         system clock, all state updates on the rising edge
//   rst_n       asynchronous active-low reset
//   apu_on      APU master enable; low holds the block cleared
//   ext_tick    (FS_EXT_TICK_EN only) external 512 Hz step strobe
//   len_tick    one-cycle strobe on steps 0,2,4,6
//   sweep_tick  one-cycle strobe on steps 2,6
//   env_tick    one-cycle strobe on step 7
//   frame_tick  one-cycle strobe on every step
//   step        index of the step that the next strobe will decode
//
// All outputs are registered; there is no combinational path from any input
// to any output.
//-----------------------------------------------------------------------------
module frame_sequencer #(
    parameter  int DIV_COUNT = 8192,
    localparam int DIV_W     = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       apu_on,
`ifdef FS_EXT_TICK_EN
    input  logic       ext_tick,
`endif
    output logic       len_tick,
    output logic       sweep_tick,
    output logic       env_tick,
    output logic       frame_tick,
    output logic [2:0] step
);

    // The strobes are only guaranteed to be separated by at least one idle
    // cycle when a step lasts two or more clocks.
    if (DIV_COUNT < 2) begin : g_bad_div
        $error("frame_sequencer: DIV_COUNT must be >= 2");
    end

    //-------------------------------------------------------------------------
    // Step event: the cycle on which the sequencer advances one step
    //-------------------------------------------------------------------------
    logic w_step_evt;

`ifdef FS_EXT_TICK_EN

    // The timer block already produces the 512 Hz strobe; ext_tick is
    // ignored while the APU is powered off.
    assign w_step_evt = apu_on & ext_tick;

`else

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_COUNT - 1);

    logic [DIV_W-1:0] r_div_cnt;

    assign w_step_evt = apu_on & (r_div_cnt == DIV_LAST);

    // Prescaler. Powering off discards any partial count so that the next
    // power-on waits a full DIV_COUNT clocks before the first strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
        end else if (!apu_on || w_step_evt) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

`endif

    //-------------------------------------------------------------------------
    // Step decode, taken from the step value before it increments
    //-------------------------------------------------------------------------
    logic [2:0] r_step;
    logic       w_len_dec;
    logic       w_sweep_dec;
    logic       w_env_dec;

    assign w_len_dec   = ~r_step[0];
    assign w_sweep_dec = (r_step == 3'd2) || (r_step == 3'd6);
    assign w_env_dec   = (r_step == 3'd7);

    //-------------------------------------------------------------------------
    // Step counter and registered strobes
    //-------------------------------------------------------------------------
    logic r_len_tick;
    logic r_sweep_tick;
    logic r_env_tick;
    logic r_frame_tick;

    // NOTE: every register here is updated with non-blocking assignments so
    // the decodes above see the step value from before this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step       <= 3'd0;
            r_len_tick   <= 1'b0;
            r_sweep_tick <= 1'b0;
            r_env_tick   <= 1'b0;
            r_frame_tick <= 1'b0;
        end else if (!apu_on) begin
            // Power-off has priority over counting and leaves no residual
            // strobe.
            r_step       <= 3'd0;
            r_len_tick   <= 1'b0;
            r_sweep_tick <= 1'b0;
            r_env_tick   <= 1'b0;
            r_frame_tick <= 1'b0;
        end else if (w_step_evt) begin
            r_step       <= r_step + 3'd1;  // wraps 7 -> 0
            r_len_tick   <= w_len_dec;
            r_sweep_tick <= w_sweep_dec;
            r_env_tick   <= w_env_dec;
            r_frame_tick <= 1'b1;
        end else begin
            r_len_tick   <= 1'b0;
            r_sweep_tick <= 1'b0;
            r_env_tick   <= 1'b0;
            r_frame_tick <= 1'b0;
        end
    end

    assign len_tick   = r_len_tick;
    assign sweep_tick = r_sweep_tick;
    assign env_tick   = r_env_tick;
    assign frame_tick = r_frame_tick;
    assign step       = r_step;

endmodule

// File: tb/tb_frame_sequencer.sv
//-----------------------------------------------------------------------------
// tb_frame_sequencer
//
// Self-checking bench for frame_sequencer with DIV_COUNT = 4. Outputs are
// compared every cycle against a reference model that counts enabled clocks
// and step events since the last power-on and derives the strobes from the
// step number arithmetically. Inputs change and outputs are sampled on the
// falling edge.
//-----------------------------------------------------------------------------
module tb_frame_sequencer;

    localparam int D = 4;
`ifdef FS_EXT_TICK_EN
    localparam bit EXT_MODE = 1'b1;
`else
    localparam bit EXT_MODE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       apu_on = 1'b0;
    logic       ext_tick = 1'b0;
    logic       len_tick, sweep_tick, env_tick, frame_tick;
    logic [2:0] step;

    always #5 clk = ~clk;

    frame_sequencer #(.DIV_COUNT(D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .apu_on     (apu_on),
`ifdef FS_EXT_TICK_EN
        .ext_tick   (ext_tick),
`endif
        .len_tick   (len_tick),
        .sweep_tick (sweep_tick),
        .env_tick   (env_tick),
        .frame_tick (frame_tick),
        .step       (step)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    //-------------------------------------------------------------------------
    // Reference model: enabled clocks and step events since power-on
    //-------------------------------------------------------------------------
    int unsigned m_clks;
    int unsigned m_evts;
    bit          e_len, e_sweep, e_env, e_frame;

    function automatic void model_clear();
        m_clks  = 0;
        m_evts  = 0;
        e_len   = 0;
        e_sweep = 0;
        e_env   = 0;
        e_frame = 0;
    endfunction

    function automatic void model_edge(input bit on, input bit ext);
        bit          fire;
        int unsigned s;
        if (!on) begin
            model_clear();
            return;
        end
        m_clks++;
        fire = EXT_MODE ? ext : ((m_clks % D) == 0);
        if (fire) begin
            s       = m_evts % 8;
            e_frame = 1;
            e_len   = (s % 2) == 0;
            e_sweep = (s == 2) || (s == 6);
            e_env   = (s == 7);
            m_evts++;
        end else begin
            e_len   = 0;
            e_sweep = 0;
            e_env   = 0;
            e_frame = 0;
        end
    endfunction

    // Observed strobe tallies, reset by the directed tests as needed.
    int cnt_frame, cnt_len, cnt_sweep, cnt_env;
    int cyc;            // cycles since the current test section started
    logic [63:0] len_mask;
    int lc_remaining;   // length counter loaded with 61 -> 3 ticks to expire
    int lc_expire_cyc;

    task automatic compare_all(input string pfx);
        check({pfx, "_frame"}, 64'(frame_tick), 64'(e_frame));
        check({pfx, "_len"},   64'(len_tick),   64'(e_len));
        check({pfx, "_sweep"}, 64'(sweep_tick), 64'(e_sweep));
        check({pfx, "_env"},   64'(env_tick),   64'(e_env));
        check({pfx, "_step"},  64'(step),       64'(m_evts % 8));
    endtask

    // One clock: drive inputs (already at a falling edge), advance the model
    // on the rising edge, compare at the next falling edge.
    task automatic cycle(input bit on, input bit ext, input string pfx);
        apu_on   = on;
        ext_tick = ext;
        @(posedge clk);
        if (rst_n) model_edge(on, ext);
        @(negedge clk);
        ext_tick = 1'b0;
        cyc++;
        compare_all(pfx);
        if (frame_tick) cnt_frame++;
        if (sweep_tick) cnt_sweep++;
        if (env_tick)   cnt_env++;
        if (len_tick) begin
            cnt_len++;
            if (cyc < 64) len_mask[cyc] = 1'b1;
            if (lc_remaining > 0) begin
                lc_remaining--;
                if (lc_remaining == 0) lc_expire_cyc = cyc;
            end
        end
    endtask

    task automatic clear_tallies();
        cnt_frame = 0; cnt_len = 0; cnt_sweep = 0; cnt_env = 0;
        cyc = 0; len_mask = '0; lc_remaining = 64 - 61; lc_expire_cyc = -1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_clear();
        compare_all("rst_async");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_clear();
        clear_tallies();

        // Reset state
        #1;
        compare_all("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

`ifndef FS_EXT_TICK_EN
        // 1: 32 clocks from power-on, plus the downstream length counter
        clear_tallies();
        for (int i = 0; i < 32; i++) cycle(1'b1, 1'b0, "t1");
        check("t1_len_cycles", len_mask,
              (64'd1 << 4) | (64'd1 << 12) | (64'd1 << 20) | (64'd1 << 28));
        check("t1_frames", 64'(cnt_frame), 64'd8);
        check("t1_sweeps", 64'(cnt_sweep), 64'd2);
        check("t1_envs",   64'(cnt_env),   64'd1);
        check("t5_len_ctr_expire_cyc", 64'(lc_expire_cyc), 64'd20);

        // 2: async reset at step 5, prescaler count 2
        cycle(1'b0, 1'b0, "t2_off");
        for (int i = 0; i < 5 * D + 2; i++) cycle(1'b1, 1'b0, "t2_run");
        check("t2_pre_step", 64'(step), 64'd5);
        apply_reset();
        clear_tallies();
        for (int i = 0; i < D; i++) cycle(1'b1, 1'b0, "t2_rel");
        check("t2_first_len_cyc", len_mask, 64'd1 << D);
        check("t2_step_after", 64'(step), 64'd1);

        // 3: power-off at step 3 on the clock that would have stepped
        cycle(1'b0, 1'b0, "t3_off0");
        for (int i = 0; i < 3 * D + (D - 1); i++) cycle(1'b1, 1'b0, "t3_run");
        check("t3_pre_step", 64'(step), 64'd3);
        clear_tallies();
        cycle(1'b0, 1'b0, "t3_off");
        check("t3_no_strobe", 64'(cnt_frame), 64'd0);
        clear_tallies();
        for (int i = 0; i < D; i++) cycle(1'b1, 1'b0, "t3_re");
        check("t3_relen_cyc", len_mask, 64'd1 << D);

        // 4: 64 clocks from a fresh power-on
        cycle(1'b0, 1'b0, "t4_off");
        clear_tallies();
        for (int i = 0; i < 64; i++) cycle(1'b1, 1'b0, "t4");
        check("t4_frames", 64'(cnt_frame), 64'd16);
        check("t4_lens",   64'(cnt_len),   64'd8);
        check("t4_sweeps", 64'(cnt_sweep), 64'd4);
        check("t4_envs",   64'(cnt_env),   64'd2);
`else
        // 6: eight irregular external ticks, then one while powered off
        clear_tallies();
        cycle(1'b1, 1'b0, "t6_idle");
        for (int p = 0; p < 8; p++) begin
            int gap = $urandom_range(0, 5);
            for (int g = 0; g < gap; g++) cycle(1'b1, 1'b0, "t6_gap");
            cycle(1'b1, 1'b1, "t6_pulse");
            check("t6_frame_follow", 64'(frame_tick), 64'd1);
        end
        check("t6_frames", 64'(cnt_frame), 64'd8);
        check("t6_envs",   64'(cnt_env),   64'd1);
        clear_tallies();
        cycle(1'b0, 1'b1, "t6_off_tick");
        cycle(1'b0, 1'b0, "t6_off");
        check("t6_off_frames", 64'(cnt_frame), 64'd0);
`endif

        // Randomized: power-on/off segments, external ticks, occasional reset
        for (int seg = 0; seg < 40; seg++) begin
            int on_len  = $urandom_range(1, 60);
            int off_len = $urandom_range(1, 4);
            for (int i = 0; i < on_len; i++)
                cycle(1'b1, EXT_MODE && ($urandom_range(0, 2) == 0), "rnd_on");
            for (int i = 0; i < off_len; i++)
                cycle(1'b0, EXT_MODE && ($urandom_range(0, 1) == 0), "rnd_off");
            if ($urandom_range(0, 7) == 0) begin
                for (int i = 0; i < int'($urandom_range(1, 9)); i++)
                    cycle(1'b1, EXT_MODE && ($urandom_range(0, 2) == 0), "rnd_pre");
                apply_reset();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
